// File: rtl/sseg_share_arbiter.sv
// Round-robin owner of the shared seven-segment display with a minimum hold.
// Ports: clk, rst (async active-low), req/req_value in; grant/done/value/owner/busy out.
module sseg_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int HOLD_CYCLES = 100000000,
  parameter int CNT_W = 27,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_value,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [7:0]           value,
  output logic [OW-1:0]        owner,
  output logic                 busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [OW-1:0]    rr, rr_d;
  logic [OW-1:0]    owner_d, nxt, pick, scan_from;
  logic [N_REQ-1:0] grant_d, done_d, others, scan_req;
  logic [7:0]       value_d;
  logic             busy_d, expired, own_req;
  logic [7:0]       slice [N_REQ];

  // first requester at or after s, wrapping mod N_REQ
  function automatic logic [OW-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [OW-1:0]    s
  );
    logic [OW:0]   idx;
    logic [OW-1:0] p;
    logic          hit;
    p   = '0;
    hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, s} + (OW+1)'(k);
      if (idx >= (OW+1)'(N_REQ))
        idx = idx - (OW+1)'(N_REQ);
      if (!hit && r[idx[OW-1:0]]) begin
        hit = 1'b1;
        p   = idx[OW-1:0];
      end
    end
    return p;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      slice[i] = req_value[8*i +: 8];
  end

  assign nxt     = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign own_req = req[owner];
  assign others  = req & ~grant;
  assign expired = (cnt == CNT_MAX);

  // handoff scans from old+1 with the old owner masked out
  assign scan_req  = (state == IDLE) ? req : others;
  assign scan_from = (state == IDLE) ? rr : nxt;
  assign pick      = rr_pick(scan_req, scan_from);

  always_comb begin
    state_d = state;
    grant_d = grant;
    done_d  = '0;
    value_d = value;
    owner_d = owner;
    busy_d  = busy;
    cnt_d   = cnt;
    rr_d    = rr;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_d = HOLD;
          grant_d = ONE << pick;
          owner_d = pick;
          value_d = slice[pick];
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if ((!own_req || expired) && |others) begin
          done_d  = grant;
          grant_d = ONE << pick;
          owner_d = pick;
          value_d = slice[pick];
          cnt_d   = '0;
          rr_d    = nxt;
        end else if (!own_req) begin
          state_d = IDLE;
          done_d  = grant;
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = nxt;
        end else begin
          value_d = slice[owner];
          if (!expired)
            cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      done  <= '0;
      value <= 8'h00;
      owner <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
      rr    <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      done  <= done_d;
      value <= value_d;
      owner <= owner_d;
      busy  <= busy_d;
      cnt   <= cnt_d;
      rr    <= rr_d;
    end
  end

endmodule
